// File: rtl/alu_wide_if.sv
// alu_wide_if: decoder-to-ALU strobe bundle and registered ALU results
interface alu_wide_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] i_db, i_adl, i_sb, o_add;
    logic i_db_add, i_db_n_add, i_adl_add, i_sb_add, i_0_add, i_1_addc;
    logic i_sums, i_ands, i_eors, i_ors, i_srs, i_daa, i_dsa;
    logic o_acr, o_avr, o_hc, o_zero, o_neg;
    modport master (
        output i_db, i_db_add, i_db_n_add, i_adl, i_adl_add, i_sb, i_sb_add, i_0_add, i_1_addc,
        output i_sums, i_ands, i_eors, i_ors, i_srs, i_daa, i_dsa,
        input o_add, o_acr, o_avr, o_hc, o_zero, o_neg
    );
    modport slave (
        input i_db, i_db_add, i_db_n_add, i_adl, i_adl_add, i_sb, i_sb_add, i_0_add, i_1_addc,
        input i_sums, i_ands, i_eors, i_ors, i_srs, i_daa, i_dsa,
        output o_add, o_acr, o_avr, o_hc, o_zero, o_neg
    );
endinterface

// File: rtl/alu_wide.sv
// alu_wide: nibble-scalable strobe-driven ALU with registered flags and optional BCD adjust
module alu_wide #(
    parameter int WIDTH = 8,
    parameter bit DECIMAL = 1'b1
) (
    input logic i_clk,
    input logic i_reset,
    alu_wide_if.slave bus
);
    localparam int N = WIDTH / 4;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, add_q, add_d;
    logic [WIDTH-1:0] bin_sum, dec_sum, sub_sum, sum_res;
    logic acr_q, acr_d, avr_q, avr_d, hc_q, hc_d, zero_q, zero_d, neg_q, neg_d;
    logic bin_c4, bin_cout, dec_cout, daa, dsa, logic_op, any_op, sum_acr, sum_avr;
    // binary and decimal carry chains ripple per nibble side by side
    always_comb begin : nibbles
        logic [N:0] bc, dc;
        logic [4:0] bt, dt;
        bc = '0;
        dc = '0;
        bt = '0;
        dt = '0;
        bin_sum = '0;
        dec_sum = '0;
        sub_sum = '0;
        bc[0] = bus.i_1_addc;
        dc[0] = bus.i_1_addc;
        for (int k = 0; k < N; k++) begin
            bt = {1'b0, a_q[4*k+:4]} + {1'b0, b_q[4*k+:4]} + 5'(bc[k]);
            dt = {1'b0, a_q[4*k+:4]} + {1'b0, b_q[4*k+:4]} + 5'(dc[k]);
            bc[k+1] = bt[4];
            dc[k+1] = dt > 5'd9;
            bin_sum[4*k+:4] = bt[3:0];
            dec_sum[4*k+:4] = dc[k+1] ? dt[3:0] + 4'd6 : dt[3:0];
            sub_sum[4*k+:4] = bt[4] ? bt[3:0] : bt[3:0] - 4'd6;
        end
        bin_c4 = bc[1];
        bin_cout = bc[N];
        dec_cout = dc[N];
    end
    always_comb begin
        daa = DECIMAL && bus.i_daa;
        dsa = DECIMAL && bus.i_dsa && !bus.i_daa;
        sum_res = daa ? dec_sum : dsa ? sub_sum : bin_sum;
        sum_acr = daa ? dec_cout : bin_cout;
        sum_avr = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (bin_sum[WIDTH-1] != a_q[WIDTH-1]);
        logic_op = bus.i_ands || bus.i_eors || bus.i_ors;
        any_op = bus.i_sums || logic_op || bus.i_srs;
        a_d = bus.i_0_add ? '0 : bus.i_sb_add ? bus.i_sb : a_q;
        b_d = bus.i_db_add ? bus.i_db : bus.i_db_n_add ? ~bus.i_db : bus.i_adl_add ? bus.i_adl : b_q;
        add_d = bus.i_sums ? sum_res :
                bus.i_ands ? a_q & b_q :
                bus.i_eors ? a_q ^ b_q :
                bus.i_ors  ? a_q | b_q :
                bus.i_srs  ? {bus.i_1_addc, a_q[WIDTH-1:1]} : add_q;
        acr_d = bus.i_sums ? sum_acr : logic_op ? 1'b0 : bus.i_srs ? a_q[0] : acr_q;
        avr_d = bus.i_sums ? sum_avr : any_op ? 1'b0 : avr_q;
        hc_d = bus.i_sums ? (DECIMAL && bin_c4) : any_op ? 1'b0 : hc_q;
        zero_d = add_d == '0;
        neg_d = add_d[WIDTH-1];
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            a_q <= '0;
            b_q <= '0;
            add_q <= '0;
            acr_q <= 1'b0;
            avr_q <= 1'b0;
            hc_q <= 1'b0;
            zero_q <= 1'b1;
            neg_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            add_q <= add_d;
            acr_q <= acr_d;
            avr_q <= avr_d;
            hc_q <= hc_d;
            zero_q <= zero_d;
            neg_q <= neg_d;
        end
    end
    assign bus.o_add = add_q;
    assign bus.o_acr = acr_q;
    assign bus.o_avr = avr_q;
    assign bus.o_hc = hc_q;
    assign bus.o_zero = zero_q;
    assign bus.o_neg = neg_q;
endmodule
